// File: rtl/mips_pkg.sv
// mips_pkg: shared load-type encodings and register constants for the MIPS datapath
package mips_pkg;
   localparam logic [2:0] LOAD_LW  = 3'd0;
   localparam logic [2:0] LOAD_LB  = 3'd1;
   localparam logic [2:0] LOAD_LBU = 3'd2;
   localparam logic [2:0] LOAD_LH  = 3'd3;
   localparam logic [2:0] LOAD_LHU = 3'd4;
   localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/load_formatter.sv
// load_formatter: big-endian byte/halfword select and extension of a loaded word
module load_formatter
   import mips_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [2:0]   load_type,
   input  logic [1:0]   off,
   input  logic [W-1:0] mem_data,
   input  logic         mem_to_reg,
   input  logic [W-1:0] alu_result,
   output logic [W-1:0] data,
   output logic         misalign
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        is_b;
   logic        is_h;
   logic        sx;
   always_comb begin
      // offset 0 addresses the most significant byte lane
      byte_sel = off == 2'd0 ? mem_data[31:24] :
                 off == 2'd1 ? mem_data[23:16] :
                 off == 2'd2 ? mem_data[15:8]  : mem_data[7:0];
      half_sel = off[1] ? mem_data[15:0] : mem_data[31:16];
      is_b     = load_type == LOAD_LB || load_type == LOAD_LBU;
      is_h     = load_type == LOAD_LH || load_type == LOAD_LHU;
      sx       = load_type == LOAD_LB || load_type == LOAD_LH;
      data     = !mem_to_reg ? alu_result :
                 is_b ? {{(W-8){sx & byte_sel[7]}}, byte_sel} :
                 is_h ? {{(W-16){sx & half_sel[15]}}, half_sel} : mem_data;
      misalign = mem_to_reg & (is_h ? off[0] : !is_b & (off != 2'd0));
   end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with load formatting, writeback drive and retire counter
module mem_wb_stage
   import mips_pkg::*;
#(
   parameter int W     = 32,
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             valid_in,
   input  logic             reg_write_in,
   input  logic             mem_to_reg_in,
   input  logic [2:0]       load_type_in,
   input  logic [4:0]       dest_reg_in,
   input  logic [W-1:0]     alu_result_in,
   input  logic [W-1:0]     mem_data_in,
   input  logic             stall_in,
   input  logic             flush_in,
   output logic [4:0]       write_reg_out,
   output logic             write_en_out,
   output logic [W-1:0]     write_data_out,
   output logic             misalign_out,
   output logic [CNT_W-1:0] retire_count_out
);
   logic [W-1:0]     fmt_data;
   logic             fmt_misalign;
   logic             valid_q;
   logic             reg_write_q;
   logic             misalign_q;
   logic [4:0]       dest_q;
   logic [W-1:0]     data_q;
   logic [CNT_W-1:0] count_q;

   load_formatter #(.W(W)) u_fmt (
      .load_type  (load_type_in),
      .off        (alu_result_in[1:0]),
      .mem_data   (mem_data_in),
      .mem_to_reg (mem_to_reg_in),
      .alu_result (alu_result_in),
      .data       (fmt_data),
      .misalign   (fmt_misalign)
   );

   always_ff @(posedge clock) begin
      if (reset || flush_in) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         misalign_q  <= 1'b0;
         dest_q      <= REG_ZERO;
         data_q      <= '0;
      end else if (!stall_in) begin
         valid_q     <= valid_in;
         reg_write_q <= reg_write_in;
         misalign_q  <= fmt_misalign;
         dest_q      <= dest_reg_in;
         data_q      <= fmt_data;
      end
      // misaligned loads still retire; trapping is handled elsewhere
      if (reset)
         count_q <= '0;
      else if (!flush_in && !stall_in && valid_in)
         count_q <= count_q + CNT_W'(1);
   end

   assign write_en_out     = valid_q & reg_write_q & !misalign_q & (dest_q != REG_ZERO);
   assign write_reg_out    = dest_q;
   assign write_data_out   = data_q;
   assign misalign_out     = valid_q & misalign_q;
   assign retire_count_out = count_q;
endmodule
